// File: rtl/diff_clock_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// diff_clock_seq_pkg : shared state encoding and loss-counter constants
// Revision: 1.0
// ---------------------------------------------------------------------------
package diff_clock_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_HOLD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_LOST  = 3'd4
  } seq_state_t;

  localparam int                    LOST_CNT_W   = 8;
  localparam logic [LOST_CNT_W-1:0] LOST_CNT_MAX = '1;

endpackage
`default_nettype wire

// File: rtl/diff_clock_seq_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// diff_clock_seq_sync : heartbeat synchronizer with registered edge pulse
// Revision: 1.0
// ---------------------------------------------------------------------------
module diff_clock_seq_sync #(
  parameter int C_SYNC_STAGES = 3
) (
  input  logic aclk,
  input  logic sreset,
  input  logic s_clk_hb,
  output logic hb_edge
);

  logic [C_SYNC_STAGES-1:0] sync_q;
  logic                     hb_last;

  always_ff @(posedge aclk) begin
    if (sreset) begin
      sync_q  <= '0;
      hb_last <= 1'b0;
      hb_edge <= 1'b0;
    end else begin
      sync_q  <= {sync_q[C_SYNC_STAGES-2:0], s_clk_hb};
      hb_last <= sync_q[C_SYNC_STAGES-1];
      hb_edge <= sync_q[C_SYNC_STAGES-1] ^ hb_last;
    end
  end

endmodule
`default_nettype wire

// File: rtl/diff_clock_reset_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// diff_clock_reset_sequencer : holds user-clock reset until the forwarded
// clock heartbeat is proven stable. Option: DIFF_CLOCK_SEQ_FREQ_MEAS_EN
// Revision: 1.0
// ---------------------------------------------------------------------------
module diff_clock_reset_sequencer
  import diff_clock_seq_pkg::*;
#(
  parameter int C_SYNC_STAGES   = 3,
  parameter int C_WINDOW_CYCLES = 1024,
  parameter int C_MIN_EDGES     = 4,
  parameter int C_HOLD_CYCLES   = 256,
  parameter int C_CNT_WIDTH     = 16
) (
  input  logic                  aclk,
  input  logic                  sreset,
  input  logic                  enable,
  input  logic                  s_clk_hb,
  output logic                  m_reset_out,
  output logic                  clk_ok,
  output logic                  clk_lost,
  output logic [LOST_CNT_W-1:0] lost_count,
  output logic [2:0]            state_o
`ifdef DIFF_CLOCK_SEQ_FREQ_MEAS_EN
  ,
  output logic [C_CNT_WIDTH-1:0] freq_count
`endif
);

  localparam logic [C_CNT_WIDTH-1:0] WIN_LAST  = C_CNT_WIDTH'(C_WINDOW_CYCLES - 1);
  localparam logic [C_CNT_WIDTH-1:0] MIN_EDGES = C_CNT_WIDTH'(C_MIN_EDGES);
  localparam logic [C_CNT_WIDTH-1:0] HOLD_LOAD = C_CNT_WIDTH'(C_HOLD_CYCLES - 1);

  seq_state_t             state;
  seq_state_t             state_nxt;
  logic                   hb_edge;
  logic                   in_window;
  logic                   win_end;
  logic                   win_good;
  logic [C_CNT_WIDTH-1:0] win_cnt;
  logic [C_CNT_WIDTH-1:0] edge_cnt;
  logic [C_CNT_WIDTH-1:0] hold_cnt;

  diff_clock_seq_sync #(
    .C_SYNC_STAGES(C_SYNC_STAGES)
  ) u_sync (
    .aclk    (aclk),
    .sreset  (sreset),
    .s_clk_hb(s_clk_hb),
    .hb_edge (hb_edge)
  );

  assign in_window = (state == ST_CHECK) || (state == ST_HOLD) || (state == ST_RUN);
  assign win_end   = in_window && (win_cnt == WIN_LAST);
  assign win_good  = (edge_cnt >= MIN_EDGES);
  assign state_o   = state;

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_CHECK;
        ST_CHECK: if (win_end && win_good) state_nxt = ST_HOLD;
        ST_HOLD: begin
          // a failed window outranks hold expiry in the same cycle
          if (win_end && !win_good)  state_nxt = ST_CHECK;
          else if (hold_cnt == '0)   state_nxt = ST_RUN;
        end
        ST_RUN:   if (win_end && !win_good) state_nxt = ST_LOST;
        ST_LOST:  state_nxt = ST_CHECK;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // outputs decode the next state so they change together with state_o
  always_ff @(posedge aclk) begin
    if (sreset) begin
      state       <= ST_IDLE;
      m_reset_out <= 1'b1;
      clk_ok      <= 1'b0;
      clk_lost    <= 1'b0;
      lost_count  <= '0;
    end else begin
      state       <= state_nxt;
      m_reset_out <= (state_nxt != ST_RUN);
      clk_ok      <= (state_nxt == ST_RUN);
      clk_lost    <= (state_nxt == ST_LOST);
      if ((state_nxt == ST_LOST) && (lost_count != LOST_CNT_MAX))
        lost_count <= lost_count + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (sreset) begin
      win_cnt  <= '0;
      edge_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      if (!in_window) begin
        win_cnt  <= '0;
        edge_cnt <= '0;
      end else if (win_end) begin
        win_cnt  <= '0;
        edge_cnt <= C_CNT_WIDTH'(hb_edge);
      end else begin
        win_cnt <= win_cnt + 1'b1;
        if (hb_edge && (edge_cnt < MIN_EDGES))
          edge_cnt <= edge_cnt + 1'b1;
      end

      if ((state == ST_CHECK) && (state_nxt == ST_HOLD))
        hold_cnt <= HOLD_LOAD;
      else if ((state == ST_HOLD) && (hold_cnt != '0))
        hold_cnt <= hold_cnt - 1'b1;
    end
  end

`ifdef DIFF_CLOCK_SEQ_FREQ_MEAS_EN
  logic [C_CNT_WIDTH-1:0] raw_cnt;

  always_ff @(posedge aclk) begin
    if (sreset) begin
      raw_cnt    <= '0;
      freq_count <= '0;
    end else if (!in_window) begin
      raw_cnt <= '0;
    end else if (win_end) begin
      freq_count <= raw_cnt;
      raw_cnt    <= C_CNT_WIDTH'(hb_edge);
    end else begin
      raw_cnt <= raw_cnt + C_CNT_WIDTH'(hb_edge);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_diff_clock_reset_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_diff_clock_reset_sequencer : randomized and directed bench with a
// cycle-level behavioural reference model. Revision: 1.0
// ---------------------------------------------------------------------------
module tb_diff_clock_reset_sequencer;

  localparam int SYNC  = 3;
  localparam int WIN   = 32;
  localparam int MINE  = 4;
  localparam int HOLDC = 40;
  localparam int CW    = 16;

  logic aclk = 1'b0;
  logic sreset = 1'b1;
  logic enable = 1'b0;
  logic s_clk_hb = 1'b0;
  logic m_reset_out, clk_ok, clk_lost;
  logic [7:0] lost_count;
  logic [2:0] state_o;
`ifdef DIFF_CLOCK_SEQ_FREQ_MEAS_EN
  logic [CW-1:0] freq_count;
`endif

  diff_clock_reset_sequencer #(
    .C_SYNC_STAGES  (SYNC),
    .C_WINDOW_CYCLES(WIN),
    .C_MIN_EDGES    (MINE),
    .C_HOLD_CYCLES  (HOLDC),
    .C_CNT_WIDTH    (CW)
  ) dut (
    .aclk       (aclk),
    .sreset     (sreset),
    .enable     (enable),
    .s_clk_hb   (s_clk_hb),
    .m_reset_out(m_reset_out),
    .clk_ok     (clk_ok),
    .clk_lost   (clk_lost),
    .lost_count (lost_count),
    .state_o    (state_o)
`ifdef DIFF_CLOCK_SEQ_FREQ_MEAS_EN
    ,
    .freq_count (freq_count)
`endif
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;
  int hb_period = 0;   // >0 toggle period, 0 frozen, <0 random level each cycle
  int hb_tick = 0;
  bit saw_run = 0;

  // reference model: states as plain ints, heartbeat as a delay line
  localparam int M_IDLE = 0, M_CHECK = 1, M_HOLD = 2, M_RUN = 3, M_LOST = 4;
  int m_st, m_wpos, m_ecnt, m_hold_age, m_lost, m_freq;
  bit m_rst = 1, m_ok, m_lp;
  bit hist [0:SYNC+1];

  function automatic void model_update();
    int nst;
    bit act, wend, good, e;
    if (sreset) begin
      m_st = M_IDLE; m_wpos = 0; m_ecnt = 0; m_hold_age = 0; m_lost = 0; m_freq = 0;
      m_rst = 1; m_ok = 0; m_lp = 0;
      for (int i = 0; i <= SYNC + 1; i++) hist[i] = 0;
      return;
    end
    e    = hist[SYNC] ^ hist[SYNC+1];
    act  = (m_st == M_CHECK) || (m_st == M_HOLD) || (m_st == M_RUN);
    wend = act && (m_wpos == WIN - 1);
    good = (m_ecnt >= MINE);
    if (!enable)                         nst = M_IDLE;
    else if (m_st == M_IDLE || m_st == M_LOST) nst = M_CHECK;
    else if (wend && !good)              nst = (m_st == M_RUN) ? M_LOST : M_CHECK;
    else if (m_st == M_CHECK)            nst = wend ? M_HOLD : M_CHECK;
    else if (m_st == M_HOLD)             nst = (m_hold_age == HOLDC - 1) ? M_RUN : M_HOLD;
    else                                 nst = M_RUN;

    if (nst == M_HOLD && m_st != M_HOLD) m_hold_age = 0;
    else if (m_st == M_HOLD)             m_hold_age++;

    if (!act) begin
      m_wpos = 0; m_ecnt = 0;
    end else if (wend) begin
      m_freq = m_ecnt % (1 << CW); m_wpos = 0; m_ecnt = int'(e);
    end else begin
      m_wpos++; m_ecnt += int'(e);
    end

    if (nst == M_LOST && m_lost < 255) m_lost++;
    m_st = nst;
    m_rst = (nst != M_RUN); m_ok = (nst == M_RUN); m_lp = (nst == M_LOST);
    for (int i = SYNC + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s_clk_hb;
  endfunction

  function automatic logic [63:0] dut_vec();
`ifdef DIFF_CLOCK_SEQ_FREQ_MEAS_EN
    return 64'({freq_count, m_reset_out, clk_ok, clk_lost, lost_count, state_o});
`else
    return 64'({m_reset_out, clk_ok, clk_lost, lost_count, state_o});
`endif
  endfunction

  function automatic logic [63:0] exp_vec();
`ifdef DIFF_CLOCK_SEQ_FREQ_MEAS_EN
    return 64'({CW'(m_freq), m_rst, m_ok, m_lp, 8'(m_lost), 3'(m_st)});
`else
    return 64'({m_rst, m_ok, m_lp, 8'(m_lost), 3'(m_st)});
`endif
  endfunction

  task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    model_update();
    #1;
    check_value("cycle", dut_vec(), exp_vec());
    if (state_o == 3'd3) saw_run = 1;
    if (hb_period > 0) begin
      hb_tick++;
      if (hb_tick >= hb_period) begin hb_tick = 0; s_clk_hb = ~s_clk_hb; end
    end else if (hb_period < 0) begin
      s_clk_hb = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int limit, input string tag);
    int n = 0;
    while (state_o != st && n < limit) begin step(); n++; end
    check_value(tag, 64'(state_o), 64'(st));
  endtask

  initial begin
    int n;
    repeat (3) step();
    check_value("reset_state", 64'({m_reset_out, clk_ok, clk_lost, lost_count, state_o}), 64'({1'b1, 1'b0, 1'b0, 8'd0, 3'd0}));
    sreset = 0;
    step();

    // bring-up latency from IDLE
    hb_period = 3; enable = 1; n = 0;
    while (m_reset_out && n < 4 * WIN + HOLDC) begin step(); n++; end
    check_value("bringup_latency", 64'(n), 64'(1 + WIN + HOLDC));
    check_value("run_clk_ok", 64'({clk_ok, state_o}), 64'({1'b1, 3'd3}));

    // heartbeat stops in RUN
    hb_period = 0;
    wait_state(3'd4, 3 * WIN, "loss_detect");
    check_value("lost_cycle", 64'({clk_lost, m_reset_out, lost_count}), 64'({1'b1, 1'b1, 8'd1}));
    step();
    check_value("lost_pulse_end", 64'({clk_lost, state_o}), 64'({1'b0, 3'd1}));

    // sub-threshold heartbeat never leaves CHECK
    hb_period = 11; saw_run = 0;
    repeat (10 * WIN) step();
    check_value("submin_state", 64'({state_o, m_reset_out, lost_count}), 64'({3'd1, 1'b1, 8'd1}));
    check_value("submin_never_run", 64'(saw_run), 64'(0));

    // heartbeat stops during HOLD
    hb_period = 3;
    wait_state(3'd2, 3 * WIN, "reach_hold");
    hb_period = 0; saw_run = 0;
    wait_state(3'd1, HOLDC + WIN, "hold_fail_to_check");
    check_value("hold_fail_no_run", 64'({saw_run, lost_count}), 64'({1'b0, 8'd1}));

    // sreset in RUN
    hb_period = 3;
    wait_state(3'd3, 4 * WIN + HOLDC, "reach_run_a");
    sreset = 1; step(); sreset = 0;
    check_value("sreset_in_run", 64'({m_reset_out, clk_ok, clk_lost, lost_count, state_o}), 64'({1'b1, 1'b0, 1'b0, 8'd0, 3'd0}));

    // enable drop in RUN
    wait_state(3'd3, 4 * WIN + HOLDC, "reach_run_b");
    enable = 0; step();
    check_value("disable_in_run", 64'({state_o, clk_lost, m_reset_out, clk_ok, lost_count}), 64'({3'd0, 1'b0, 1'b1, 1'b0, 8'd0}));

`ifdef DIFF_CLOCK_SEQ_FREQ_MEAS_EN
    hb_period = 8; enable = 1;
    repeat (5 * WIN) step();
    check_value("freq_count", 64'(freq_count), 64'(WIN / 8));
`endif

    // loss counter saturation
    enable = 1;
    for (int k = 0; k < 300; k++) begin
      hb_period = 3;
      wait_state(3'd3, 4 * WIN + HOLDC, "sat_reach_run");
      hb_period = 0;
      wait_state(3'd4, 3 * WIN, "sat_loss");
      if (state_o != 3'd4) break;
    end
    step();
    check_value("lost_saturate", 64'(lost_count), 64'(255));

    // randomized segments against the model
    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 3))
        0:       hb_period = 0;
        1:       hb_period = -1;
        default: hb_period = int'($urandom_range(2, 12));
      endcase
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) begin sreset = 1; step(); sreset = 0; end
      repeat (60) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
